// File: rtl/router.sv
// ---------------------------------------------------------------------------
// router
//   Single-buffer mesh router node. One DATA_W buffer captures the incoming
//   flit from any enabled input port. A one-cycle command forwards the
//   buffer to a neighbour or to the local IP. The east/west target is chosen
//   by row parity, and the north/south target by col parity.
//
// Ports
//   clk                 rising-edge clock for all state
//   rst                 asynchronous active-low reset
//   vertical_rotate     send buffer to vertical neighbour (col[0]: 0=south, 1=north)
//   horizon_rotate      send buffer to horizontal neighbour (row[0]: 0=east, 1=west)
//   ip_router_exchange  send buffer to local IP
//   row, col            mesh position of this node (quasi-static)
//   <port>_in_data/_en  incoming flit + valid for east/west/north/south/ip
//   <port>_out_data/_en outgoing flit + valid (registered) for each port
// ---------------------------------------------------------------------------
module router #(
    parameter int DATA_W  = 256,
    parameter int COORD_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vertical_rotate,
    input  logic               horizon_rotate,
    input  logic               ip_router_exchange,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    input  logic [DATA_W-1:0]  east_in_data,
    input  logic               east_in_en,
    input  logic [DATA_W-1:0]  west_in_data,
    input  logic               west_in_en,
    input  logic [DATA_W-1:0]  north_in_data,
    input  logic               north_in_en,
    input  logic [DATA_W-1:0]  south_in_data,
    input  logic               south_in_en,
    input  logic [DATA_W-1:0]  ip_in_data,
    input  logic               ip_in_en,
    output logic [DATA_W-1:0]  east_out_data,
    output logic               east_out_en,
    output logic [DATA_W-1:0]  west_out_data,
    output logic               west_out_en,
    output logic [DATA_W-1:0]  north_out_data,
    output logic               north_out_en,
    output logic [DATA_W-1:0]  south_out_data,
    output logic               south_out_en,
    output logic [DATA_W-1:0]  ip_out_data,
    output logic               ip_out_en
);

    logic [DATA_W-1:0] buf_q;

    // Only the parity bit of each coordinate steers routing.
    logic unused_coord_bits;
    assign unused_coord_bits = ^{row, col};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q          <= '0;
            east_out_data  <= '0;
            west_out_data  <= '0;
            north_out_data <= '0;
            south_out_data <= '0;
            ip_out_data    <= '0;
            east_out_en    <= 1'b0;
            west_out_en    <= 1'b0;
            north_out_en   <= 1'b0;
            south_out_en   <= 1'b0;
            ip_out_en      <= 1'b0;
        end else begin
            // Valid strobes are single-cycle pulses; data registers hold.
            east_out_en  <= 1'b0;
            west_out_en  <= 1'b0;
            north_out_en <= 1'b0;
            south_out_en <= 1'b0;
            ip_out_en    <= 1'b0;

            // Sends read buf_q before this edge's write, so a send and a
            // receive in the same cycle swap cleanly.
            if (ip_router_exchange) begin
                ip_out_data <= buf_q;
                ip_out_en   <= 1'b1;
            end else if (horizon_rotate) begin
                if (!row[0]) begin
                    east_out_data <= buf_q;
                    east_out_en   <= 1'b1;
                end else begin
                    west_out_data <= buf_q;
                    west_out_en   <= 1'b1;
                end
            end else if (vertical_rotate) begin
                if (!col[0]) begin
                    south_out_data <= buf_q;
                    south_out_en   <= 1'b1;
                end else begin
                    north_out_data <= buf_q;
                    north_out_en   <= 1'b1;
                end
            end

            if (ip_in_en)         buf_q <= ip_in_data;
            else if (west_in_en)  buf_q <= west_in_data;
            else if (east_in_en)  buf_q <= east_in_data;
            else if (north_in_en) buf_q <= north_in_data;
            else if (south_in_en) buf_q <= south_in_data;
        end
    end

endmodule

// File: tb/tb_router.sv
module tb_router;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          vertical_rotate, horizon_rotate, ip_router_exchange;
    logic [CW-1:0] row, col;
    logic [DW-1:0] east_in_data, west_in_data, north_in_data, south_in_data, ip_in_data;
    logic          east_in_en, west_in_en, north_in_en, south_in_en, ip_in_en;
    logic [DW-1:0] east_out_data, west_out_data, north_out_data, south_out_data, ip_out_data;
    logic          east_out_en, west_out_en, north_out_en, south_out_en, ip_out_en;

    router #(.DATA_W(DW), .COORD_W(CW)) dut (
        .clk(clk), .rst(rst),
        .vertical_rotate(vertical_rotate), .horizon_rotate(horizon_rotate),
        .ip_router_exchange(ip_router_exchange),
        .row(row), .col(col),
        .east_in_data(east_in_data),   .east_in_en(east_in_en),
        .west_in_data(west_in_data),   .west_in_en(west_in_en),
        .north_in_data(north_in_data), .north_in_en(north_in_en),
        .south_in_data(south_in_data), .south_in_en(south_in_en),
        .ip_in_data(ip_in_data),       .ip_in_en(ip_in_en),
        .east_out_data(east_out_data),   .east_out_en(east_out_en),
        .west_out_data(west_out_data),   .west_out_en(west_out_en),
        .north_out_data(north_out_data), .north_out_en(north_out_en),
        .south_out_data(south_out_data), .south_out_en(south_out_en),
        .ip_out_data(ip_out_data),       .ip_out_en(ip_out_en)
    );

    always #5 clk = ~clk;

    // Port bit order everywhere: {ip, east, west, north, south}.
    // Input data per port is derived from d: ip=d, west=d+1, east=d+2,
    // north=d+3, south=d+4, so the chosen source is visible in buf.
    typedef struct {
        logic          row0;
        logic          col0;
        logic [2:0]    cmd;      // {ip_router_exchange, horizon_rotate, vertical_rotate}
        logic [4:0]    in_en;
        logic [DW-1:0] d;
        logic [4:0]    exp_en;
        logic [DW-1:0] exp_d;    // value on the pulsing port
    } vec_t;

    localparam int NV = 20;
    vec_t vec [NV];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [DW-1:0] hold [5];

    function automatic logic [4:0] out_en_bus();
        return {ip_out_en, east_out_en, west_out_en, north_out_en, south_out_en};
    endfunction

    function automatic logic [5*DW-1:0] out_data_bus();
        return {ip_out_data, east_out_data, west_out_data, north_out_data, south_out_data};
    endfunction

    task automatic check(input string name, input logic [5*DW-1:0] got, input logic [5*DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic drive(input vec_t v);
        row = {{(CW-1){1'b0}}, v.row0};
        col = {{(CW-1){1'b0}}, v.col0};
        {ip_router_exchange, horizon_rotate, vertical_rotate} = v.cmd;
        {ip_in_en, east_in_en, west_in_en, north_in_en, south_in_en} = v.in_en;
        ip_in_data    = v.d;
        west_in_data  = v.d + 1;
        east_in_data  = v.d + 2;
        north_in_data = v.d + 3;
        south_in_data = v.d + 4;
    endtask

    task automatic idle_inputs();
        vec_t z;
        z = '{row0:1'b0, col0:1'b0, cmd:3'b000, in_en:5'b0, d:'0, exp_en:5'b0, exp_d:'0};
        drive(z);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          row col cmd     in_en     d      exp_en    exp_d
        vec[0]  = '{1'b0, 1'b0, 3'b100, 5'b00000, 32'h00, 5'b10000, 32'h00}; // unwritten buf sends 0
        vec[1]  = '{1'b0, 1'b0, 3'b000, 5'b10000, 32'h01, 5'b00000, 32'h00}; // load 1 from ip
        vec[2]  = '{1'b0, 1'b0, 3'b010, 5'b00000, 32'h00, 5'b01000, 32'h01}; // row0 -> east
        vec[3]  = '{1'b0, 1'b0, 3'b000, 5'b00000, 32'h00, 5'b00000, 32'h00}; // idle, en drops
        vec[4]  = '{1'b0, 1'b0, 3'b100, 5'b00000, 32'h00, 5'b10000, 32'h01}; // buf retained
        vec[5]  = '{1'b1, 1'b0, 3'b010, 5'b00000, 32'h00, 5'b00100, 32'h01}; // row1 -> west
        vec[6]  = '{1'b0, 1'b1, 3'b001, 5'b00000, 32'h00, 5'b00010, 32'h01}; // col1 -> north
        vec[7]  = '{1'b0, 1'b0, 3'b001, 5'b00000, 32'h00, 5'b00001, 32'h01}; // col0 -> south
        vec[8]  = '{1'b0, 1'b0, 3'b000, 5'b10000, 32'h05, 5'b00000, 32'h00}; // buf=5
        vec[9]  = '{1'b0, 1'b0, 3'b010, 5'b00100, 32'h08, 5'b01000, 32'h05}; // swap: west in 9
        vec[10] = '{1'b0, 1'b0, 3'b100, 5'b00000, 32'h00, 5'b10000, 32'h09}; // ip gets 9
        vec[11] = '{1'b0, 1'b0, 3'b000, 5'b10100, 32'h20, 5'b00000, 32'h00}; // ip beats west
        vec[12] = '{1'b0, 1'b0, 3'b111, 5'b00000, 32'h00, 5'b10000, 32'h20}; // ip cmd wins
        vec[13] = '{1'b0, 1'b0, 3'b000, 5'b01011, 32'h30, 5'b00000, 32'h00}; // east beats n/s
        vec[14] = '{1'b0, 1'b0, 3'b001, 5'b00011, 32'h40, 5'b00001, 32'h32}; // north beats s
        vec[15] = '{1'b1, 1'b0, 3'b010, 5'b00001, 32'h50, 5'b00100, 32'h43}; // south alone
        vec[16] = '{1'b0, 1'b1, 3'b011, 5'b00000, 32'h00, 5'b01000, 32'h54}; // h beats v
        vec[17] = '{1'b0, 1'b0, 3'b100, 5'b00000, 32'h00, 5'b10000, 32'h54};
        vec[18] = '{1'b0, 1'b0, 3'b100, 5'b00000, 32'h00, 5'b10000, 32'h54}; // repeated: stays high
        vec[19] = '{1'b0, 1'b0, 3'b000, 5'b00000, 32'h00, 5'b00000, 32'h00};

        for (int i = 0; i < 5; i++) hold[i] = '0;

        rst = 1'b0;
        idle_inputs();
        #12;
        check("reset_en", {{(5*DW-5){1'b0}}, out_en_bus()}, '0);
        check("reset_data", out_data_bus(), '0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vec[i]);
            step();
            for (int p = 0; p < 5; p++)
                if (vec[i].exp_en[4-p]) hold[p] = vec[i].exp_d;
            check($sformatf("vec%0d_en", i), {{(5*DW-5){1'b0}}, out_en_bus()},
                  {{(5*DW-5){1'b0}}, vec[i].exp_en});
            check($sformatf("vec%0d_data", i), out_data_bus(),
                  {hold[0], hold[1], hold[2], hold[3], hold[4]});
        end

        // Asynchronous reset mid-pulse: outputs clear without a clock edge.
        ip_router_exchange = 1'b1;
        step();
        check("pre_reset_ip", {{(4*DW-1){1'b0}}, ip_out_en, ip_out_data},
              {{(4*DW-1){1'b0}}, 1'b1, 32'h54});
        #2 rst = 1'b0;
        #1;
        check("async_rst_en", {{(5*DW-5){1'b0}}, out_en_bus()}, '0);
        check("async_rst_data", out_data_bus(), '0);

        // Command held across an edge while in reset yields no pulse.
        step();
        check("rst_cancel_en", {{(5*DW-5){1'b0}}, out_en_bus()}, '0);
        @(negedge clk);
        rst = 1'b1;
        ip_router_exchange = 1'b0;
        step();
        check("post_rst_idle", {{(5*DW-5){1'b0}}, out_en_bus()}, '0);

        // buf was cleared by reset.
        ip_router_exchange = 1'b1;
        step();
        check("post_rst_buf", {{(4*DW-1){1'b0}}, ip_out_en, ip_out_data},
              {{(4*DW-1){1'b0}}, 1'b1, 32'h00});
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/router.md
ROUTER -- requirements
Module: router

Interface
REQ-001 Parameter DATA_W, default 256, width of every data port and of the internal buffer.
REQ-002 Parameter COORD_W, default 4, width of row and col.
REQ-003 Single clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-low reset (0 = reset, 1 = run).
REQ-006 vertical_rotate  input  1  one-cycle command: send the buffer to the vertical neighbour.
REQ-007 horizon_rotate  input  1  one-cycle command: send the buffer to the horizontal neighbour.
REQ-008 ip_router_exchange  input  1  one-cycle command: send the buffer to the local IP.
REQ-009 row, col  input  COORD_W each  mesh position of this node; quasi-static.
REQ-010 east_in_data/east_in_en, west_in_data/west_in_en, north_in_data/north_in_en, south_in_data/south_in_en, ip_in_data/ip_in_en  input  DATA_W/1  incoming flit and valid per port.
REQ-011 east_out_data/east_out_en, west_out_data/west_out_en, north_out_data/north_out_en, south_out_data/south_out_en, ip_out_data/ip_out_en  output  DATA_W/1  outgoing flit and valid per port; all registered.

Function
REQ-012 One DATA_W buffer register buf; no other data storage.
REQ-013 Buffer write: on a clk edge with any *_in_en high, buf takes that port's data; if several are high, priority is ip > west > east > north > south.
REQ-014 buf holds its value when no *_in_en is high; sending never clears buf.
REQ-015 Commands are sampled at the clk edge; when several are high, priority is ip_router_exchange > horizon_rotate > vertical_rotate; only one is executed per cycle.
REQ-016 horizon_rotate with row[0]==0: east_out_data <= buf and east_out_en <= 1.
REQ-017 horizon_rotate with row[0]==1: west_out_data <= buf and west_out_en <= 1.
REQ-018 vertical_rotate with col[0]==0: south_out_data <= buf and south_out_en <= 1.
REQ-019 vertical_rotate with col[0]==1: north_out_data <= buf and north_out_en <= 1.
REQ-020 ip_router_exchange: ip_out_data <= buf and ip_out_en <= 1.
REQ-021 Sends use the value of buf before the same-edge write, so a send and a receive in the same cycle swap data with no loss.
REQ-022 Latency: command at edge N makes *_out_en high for exactly the cycle after edge N; the en bit returns to 0 at edge N+1 unless the command is repeated.
REQ-023 *_out_data holds its last sent value when *_out_en is 0.
REQ-024 A command issued with a never-written buf sends 0.

Reset
REQ-025 While rst==0, asynchronously clear buf, every *_out_data and every *_out_en to 0.
REQ-026 On rst deassertion, the first rising edge processes inputs normally; a reset during a command cancels the pending out_en pulse.

Verification
REQ-027 Load then rotate: row=col=0, ip_in_data=1, ip_in_en=1 for one cycle, then horizon_rotate=1 for one cycle -> east_out_data=1 with east_out_en=1 for exactly one cycle; all other out_en stay 0.
REQ-028 Continuation of REQ-027, one idle cycle, then ip_router_exchange=1 for one cycle -> ip_out_data=1 with ip_out_en=1 for one cycle (buf retained after the rotate).
REQ-029 Parity routing: row=1 horizon_rotate -> west_out_en pulses; col=1 vertical_rotate -> north_out_en pulses; col=0 vertical_rotate -> south_out_en pulses.
REQ-030 Swap: buf=5, west_in_data=9 with west_in_en=1 in the same cycle as horizon_rotate (row=0) -> east_out_data=5, and the following exchange gives ip_out_data=9.
REQ-031 Priorities: ip_in_en and west_in_en both high -> buf takes the ip data; all three commands high together -> only ip_out_en pulses.
REQ-032 Reset: rst driven low mid-operation -> buf, all outputs and all out_en are 0 immediately, without waiting for a clk edge.
